// File: rtl/gru_seq_ctrl.sv
// gru_seq_ctrl: sequences one GRU step (gates z, r, h) over a shared MAC/activation datapath.
// For each gate and each output i it loads the bias, accumulates M input products and N
// recurrent products, waits for the activation unit, then writes the gate result.
// Build option: define GRU_CTRL_RELU_EN to select relu instead of tanh for gate h.
module gru_seq_ctrl #(
  parameter int unsigned M    = 24,
  parameter int unsigned N    = 24,
  parameter int unsigned IA_W = 11,
  parameter int unsigned RA_W = 11,
  parameter int unsigned BA_W = 7,
  parameter int unsigned IX_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [BA_W-1:0] bias_addr,
  output logic [IA_W-1:0] iw_addr,
  output logic [RA_W-1:0] rw_addr,
  output logic [IX_W-1:0] vec_idx,
  output logic            mac_load,
  output logic            mac_en,
  output logic            mac_rec,
  output logic            mac_use_r,
  output logic [1:0]      gate,
  output logic            act_req,
  input  logic            act_ack,
  output logic [1:0]      act_sel,
  output logic            wr_en,
  output logic            upd_en,
  output logic [IX_W-1:0] out_idx
);

  localparam int unsigned STRIDE = 3 * N;

  localparam logic [1:0] GATE_H   = 2'd2;
  localparam logic [1:0] SEL_SIG  = 2'd0;
  localparam logic [1:0] SEL_TANH = 2'd1;
  localparam logic [1:0] SEL_RELU = 2'd2;

`ifdef GRU_CTRL_RELU_EN
  localparam logic [1:0] H_SEL = SEL_RELU;
`else
  localparam logic [1:0] H_SEL = SEL_TANH;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_IN_MAC, S_REC_MAC, S_ACT, S_WR, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      gate_q, gate_d;
  logic [IX_W-1:0] i_q, i_d;
  logic [IX_W-1:0] v_q, v_d;

  logic [31:0] gate_off;
  logic [31:0] i_u;
  logic [31:0] v_off;
  logic        last_i, last_in, last_rec, is_h;

  // Address terms in full 32-bit width before narrowing to the port widths
  assign gate_off = 32'(gate_q) * N;
  assign i_u      = 32'(i_q);
  assign v_off    = 32'(v_q) * STRIDE;
  assign last_i   = (i_u == N - 1);
  assign last_in  = (32'(v_q) == M - 1);
  assign last_rec = (32'(v_q) == N - 1);
  assign is_h     = (gate_q == GATE_H);

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gate_q  <= '0;
      i_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      i_q     <= i_d;
      v_q     <= v_d;
    end
  end

  // Next-state, counter updates and per-state datapath controls
  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    i_d       = i_q;
    v_d       = v_q;
    busy      = 1'b0;
    done      = 1'b0;
    bias_addr = '0;
    iw_addr   = '0;
    rw_addr   = '0;
    vec_idx   = '0;
    mac_load  = 1'b0;
    mac_en    = 1'b0;
    mac_rec   = 1'b0;
    mac_use_r = 1'b0;
    gate      = '0;
    act_req   = 1'b0;
    act_sel   = SEL_SIG;
    wr_en     = 1'b0;
    upd_en    = 1'b0;
    out_idx   = '0;

    if (state_q != S_IDLE) begin
      busy    = 1'b1;
      gate    = gate_q;
      out_idx = i_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BIAS;
          gate_d  = '0;
          i_d     = '0;
          v_d     = '0;
        end
      end
      S_BIAS: begin
        mac_load  = 1'b1;
        bias_addr = BA_W'(gate_off + i_u);
        v_d       = '0;
        state_d   = S_IN_MAC;
      end
      S_IN_MAC: begin
        mac_en  = 1'b1;
        vec_idx = v_q;
        iw_addr = IA_W'(gate_off + v_off + i_u);
        if (last_in) begin
          v_d     = '0;
          state_d = S_REC_MAC;
        end else begin
          v_d = v_q + IX_W'(1);
        end
      end
      S_REC_MAC: begin
        mac_en    = 1'b1;
        mac_rec   = 1'b1;
        mac_use_r = is_h;
        vec_idx   = v_q;
        rw_addr   = RA_W'(gate_off + v_off + i_u);
        if (last_rec) begin
          v_d     = '0;
          state_d = S_ACT;
        end else begin
          v_d = v_q + IX_W'(1);
        end
      end
      S_ACT: begin
        act_req = 1'b1;
        act_sel = is_h ? H_SEL : SEL_SIG;
        if (act_ack) state_d = S_WR;
      end
      S_WR: begin
        wr_en  = 1'b1;
        upd_en = is_h;
        if (last_i) begin
          i_d = '0;
          if (is_h) begin
            state_d = S_DONE;
          end else begin
            gate_d  = gate_q + 2'd1;
            state_d = S_BIAS;
          end
        end else begin
          i_d     = i_q + IX_W'(1);
          state_d = S_BIAS;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        gate_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
